// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory arbiter and its grant picker:
//   - dm_arb_state_e : ownership state of the shared memory port
//   - P0 / P1        : requester indices (core / loader-debug master)
//   - LOCK_MAX_DEFAULT : default limit on consecutive locked port-1 beats
//   - STALL_W        : width of the optional stall counters
// -----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // nobody was served last cycle
        OWN0  = 2'd1,   // port 0 was served last cycle
        OWN1  = 2'd2,   // port 1 was served last cycle, unlocked
        OWN1L = 2'd3    // port 1 was served last cycle under lock
    } dm_arb_state_e;

    localparam int P0 = 0;
    localparam int P1 = 1;

    localparam int LOCK_MAX_DEFAULT = 8;
    localparam int STALL_W          = 16;

endpackage

// File: rtl/dm_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// dm_arb_rr_pick
// Combinational 2-way grant decision with round-robin tie break and a
// port-1 lock extension.
// Ports:
//   enable     in  : arbitration allowed (low forces no grant)
//   req[1:0]   in  : per-port requests
//   last_owner in  : 0 = port 0 served most recently, 1 = port 1
//   locked     in  : port 1 was served under lock last cycle
//   lock_hold  in  : port 1 still asks for lock and has beats left
//   gnt[1:0]   out : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module dm_arb_rr_pick
    import dm_arb_pkg::*;
(
    input  logic       enable,
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       locked,
    input  logic       lock_hold,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (locked && req[P1] && lock_hold) begin
                gnt[P1] = 1'b1;
            end else if (req[P0] && req[P1]) begin
                // Tie: the port that was not served last wins. An expired
                // or dropped lock always has last_owner = 1, so this is
                // also the forced hand-back to port 0.
                if (last_owner) begin
                    gnt[P0] = 1'b1;
                end else begin
                    gnt[P1] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares one single-port data memory between the core (port 0) and a
// loader/debug master (port 1). Grants and memory controls are
// combinational; read data is registered and flagged by a one-cycle
// RVALID pulse after the accepting edge.
// Optional feature macro: DM_ARB_STATS_EN adds saturating 16-bit stall
// counters STALL0_CNT / STALL1_CNT.
// Ports:
//   CLK, RST_N                  : clock, asynchronous active-low reset
//   Rx_REQ/WE/A/WD              : requester x access (x = 0, 1)
//   Rx_GNT                      : requester x granted this cycle
//   Rx_RD, Rx_RVALID            : registered read data and valid pulse
//   R1_LOCK                     : port 1 asks for back-to-back ownership
//   DMWE, DMA, DMWD, DMRD       : memory interface (DMRD asynchronous)
//   STALL0_CNT, STALL1_CNT      : stall counters (DM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int WL       = 32,
    parameter int AL       = 9,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               R0_REQ,
    input  logic               R0_WE,
    input  logic [AL-1:0]      R0_A,
    input  logic [WL-1:0]      R0_WD,
    output logic               R0_GNT,
    output logic [WL-1:0]      R0_RD,
    output logic               R0_RVALID,
    input  logic               R1_REQ,
    input  logic               R1_WE,
    input  logic [AL-1:0]      R1_A,
    input  logic [WL-1:0]      R1_WD,
    output logic               R1_GNT,
    output logic [WL-1:0]      R1_RD,
    output logic               R1_RVALID,
    input  logic               R1_LOCK,
`ifdef DM_ARB_STATS_EN
    output logic [STALL_W-1:0] STALL0_CNT,
    output logic [STALL_W-1:0] STALL1_CNT,
`endif
    output logic               DMWE,
    output logic [AL-1:0]      DMA,
    output logic [WL-1:0]      DMWD,
    input  logic [WL-1:0]      DMRD
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);

    dm_arb_state_e state_reg, state_next;
    logic          last_owner_reg, last_owner_next;
    logic [CW-1:0] lock_cnt_reg, lock_cnt_next;

    logic [1:0]         req;
    logic [1:0]         we;
    logic [1:0][AL-1:0] addr;
    logic [1:0][WL-1:0] wdata;
    logic [1:0]         gnt;
    logic [1:0]         rd_accept;
    logic               lock_hold;

    logic [1:0][WL-1:0] rd_reg;
    logic [1:0]         rvalid_reg;

    assign req   = {R1_REQ, R0_REQ};
    assign we    = {R1_WE, R0_WE};
    assign addr  = {R1_A, R0_A};
    assign wdata = {R1_WD, R0_WD};

    assign lock_hold = R1_LOCK && (lock_cnt_reg < LOCK_LIMIT);

    // Reset level gates the grant so nothing reaches memory while RST_N is low.
    dm_arb_rr_pick u_pick (
        .enable     (RST_N),
        .req        (req),
        .last_owner (last_owner_reg),
        .locked     (state_reg == OWN1L),
        .lock_hold  (lock_hold),
        .gnt        (gnt)
    );

    assign R0_GNT = gnt[P0];
    assign R1_GNT = gnt[P1];

    // Memory-side mux; all zeros when nobody holds the grant.
    always_comb begin
        DMWE = 1'b0;
        DMA  = '0;
        DMWD = '0;
        if (gnt[P0]) begin
            DMWE = we[P0];
            DMA  = addr[P0];
            DMWD = wdata[P0];
        end else if (gnt[P1]) begin
            DMWE = we[P1];
            DMA  = addr[P1];
            DMWD = wdata[P1];
        end
    end

    // Ownership state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
            lock_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            lock_cnt_reg   <= lock_cnt_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next      = IDLE;
        last_owner_next = last_owner_reg;
        lock_cnt_next   = '0;
        if (gnt[P0]) begin
            state_next      = OWN0;
            last_owner_next = 1'b0;
        end else if (gnt[P1]) begin
            last_owner_next = 1'b1;
            if (R1_LOCK) begin
                state_next = OWN1L;
                if (state_reg != OWN1L) begin
                    lock_cnt_next = CW'(1);
                end else if (lock_cnt_reg < LOCK_LIMIT) begin
                    lock_cnt_next = lock_cnt_reg + CW'(1);
                end else begin
                    // Port 1 alone under an exhausted lock: stay pinned at
                    // the limit so port 0 wins as soon as it asks.
                    lock_cnt_next = lock_cnt_reg;
                end
            end else begin
                state_next = OWN1;
            end
        end
    end

    // Per-port read return path (and optional stall counters).
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign rd_accept[gi] = gnt[gi] & req[gi] & ~we[gi];

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                rd_reg[gi]     <= '0;
                rvalid_reg[gi] <= 1'b0;
            end else begin
                rvalid_reg[gi] <= rd_accept[gi];
                if (rd_accept[gi]) begin
                    rd_reg[gi] <= DMRD;
                end
            end
        end

`ifdef DM_ARB_STATS_EN
        logic [STALL_W-1:0] stall_cnt_reg;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                stall_cnt_reg <= '0;
            end else if (req[gi] && !gnt[gi] && (stall_cnt_reg != {STALL_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
`endif
    end

    assign R0_RD     = rd_reg[P0];
    assign R1_RD     = rd_reg[P1];
    assign R0_RVALID = rvalid_reg[P0];
    assign R1_RVALID = rvalid_reg[P1];

`ifdef DM_ARB_STATS_EN
    assign STALL0_CNT = g_port[0].stall_cnt_reg;
    assign STALL1_CNT = g_port[1].stall_cnt_reg;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed scenarios followed by a randomized phase, all checked against a
// behavioural model of the arbitration rules and of memory contents.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int WL   = 32;
    localparam int AL   = 9;
    localparam int LMAX = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          r0_req, r0_we, r1_req, r1_we, r1_lock;
    logic [AL-1:0] r0_a, r1_a;
    logic [WL-1:0] r0_wd, r1_wd;
    logic          R0_GNT, R1_GNT, R0_RVALID, R1_RVALID, DMWE;
    logic [WL-1:0] R0_RD, R1_RD, DMWD, DMRD;
    logic [AL-1:0] DMA;
`ifdef DM_ARB_STATS_EN
    logic [15:0]   STALL0_CNT, STALL1_CNT;
`endif

    logic [WL-1:0] mem [0:(1<<AL)-1];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WL-1:0] exp_mem [0:(1<<AL)-1];
    logic [WL-1:0] exp_rd [2];
    logic          exp_rv [2];
    int            m_last, m_run, m_locked;
    int            m_stall [2];
    int            obs_g;
    logic          obs_we;
    int            seq [20];

    always #5 CLK = ~CLK;

    dm_arbiter #(.WL(WL), .AL(AL), .LOCK_MAX(LMAX)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .R0_REQ(r0_req), .R0_WE(r0_we), .R0_A(r0_a), .R0_WD(r0_wd),
        .R0_GNT(R0_GNT), .R0_RD(R0_RD), .R0_RVALID(R0_RVALID),
        .R1_REQ(r1_req), .R1_WE(r1_we), .R1_A(r1_a), .R1_WD(r1_wd),
        .R1_GNT(R1_GNT), .R1_RD(R1_RD), .R1_RVALID(R1_RVALID),
        .R1_LOCK(r1_lock),
`ifdef DM_ARB_STATS_EN
        .STALL0_CNT(STALL0_CNT), .STALL1_CNT(STALL1_CNT),
`endif
        .DMWE(DMWE), .DMA(DMA), .DMWD(DMWD), .DMRD(DMRD)
    );

    // Behavioural single-port memory with asynchronous read
    always @(posedge CLK) if (DMWE) mem[DMA] <= DMWD;
    assign DMRD = mem[DMA];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_last   = 1;
        m_run    = 0;
        m_locked = 0;
        for (int p = 0; p < 2; p++) begin
            exp_rd[p]  = '0;
            exp_rv[p]  = 1'b0;
            m_stall[p] = 0;
        end
    endtask

    // Who should own the memory this cycle, from the arbitration rules.
    function automatic int model_grant();
        if (RST_N !== 1'b1) return -1;
        if (m_locked != 0 && r1_req && r1_lock && m_run < LMAX) return 1;
        if (r0_req && r1_req) return 1 - m_last;
        if (r0_req) return 0;
        if (r1_req) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (r0_req && g != 0 && m_stall[0] < 16'hFFFF) m_stall[0]++;
        if (r1_req && g != 1 && m_stall[1] < 16'hFFFF) m_stall[1]++;
        if (g == 0) begin
            if (r0_we) exp_mem[r0_a] = r0_wd;
            else begin exp_rd[0] = exp_mem[r0_a]; exp_rv[0] = 1'b1; end
            m_last = 0; m_locked = 0; m_run = 0;
        end else if (g == 1) begin
            if (r1_we) exp_mem[r1_a] = r1_wd;
            else begin exp_rd[1] = exp_mem[r1_a]; exp_rv[1] = 1'b1; end
            m_last = 1;
            if (r1_lock) begin
                m_run    = (m_locked != 0) ? ((m_run < LMAX) ? m_run + 1 : m_run) : 1;
                m_locked = 1;
            end else begin
                m_locked = 0; m_run = 0;
            end
        end else begin
            m_locked = 0; m_run = 0;
        end
    endtask

    // One bus cycle: entered at posedge+1 with inputs already driven.
    task automatic tick();
        int g;
        logic          e_we;
        logic [31:0]   e_dma, e_dwd;
        #3;
        g = model_grant();
        e_we = 1'b0; e_dma = '0; e_dwd = '0;
        if (g == 0) begin e_we = r0_we; e_dma = 32'(r0_a); e_dwd = r0_wd; end
        if (g == 1) begin e_we = r1_we; e_dma = 32'(r1_a); e_dwd = r1_wd; end
        obs_g  = R0_GNT ? 0 : (R1_GNT ? 1 : -1);
        obs_we = DMWE;
        chk("r0_gnt", 32'(R0_GNT), 32'(g == 0));
        chk("r1_gnt", 32'(R1_GNT), 32'(g == 1));
        chk("dmwe",   32'(DMWE), 32'(e_we));
        chk("dma",    32'(DMA), e_dma);
        chk("dmwd",   DMWD, e_dwd);
`ifdef DM_ARB_STATS_EN
        chk("stall0", 32'(STALL0_CNT), 32'(m_stall[0]));
        chk("stall1", 32'(STALL1_CNT), 32'(m_stall[1]));
`endif
        @(posedge CLK);
        model_update(g);
        #1;
        chk("r0_rvalid", 32'(R0_RVALID), 32'(exp_rv[0]));
        chk("r1_rvalid", 32'(R1_RVALID), 32'(exp_rv[1]));
        chk("r0_rd", R0_RD, exp_rd[0]);
        chk("r1_rd", R1_RD, exp_rd[1]);
        $display("cycle g=%0d obs=%0d we=%0b dma=%0d r0rv=%0b r1rv=%0b", g, obs_g, obs_we, DMA, R0_RVALID, R1_RVALID);
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_we = 0; r0_a = '0; r0_wd = '0;
        r1_req = 0; r1_we = 0; r1_a = '0; r1_wd = '0; r1_lock = 0;
    endtask

    // Entered and left at posedge+1; checks outputs while reset is low.
    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        #3;
        chk("rst_r0_gnt", 32'(R0_GNT), 32'd0);
        chk("rst_r1_gnt", 32'(R1_GNT), 32'd0);
        chk("rst_dmwe", 32'(DMWE), 32'd0);
        @(posedge CLK); #1;
        chk("rst_r0_rvalid", 32'(R0_RVALID), 32'd0);
        chk("rst_r1_rvalid", 32'(R1_RVALID), 32'd0);
        chk("rst_r0_rd", R0_RD, 32'd0);
        chk("rst_r1_rd", R1_RD, 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        idle_inputs();
        r0_req = 1; r1_req = 1;     // requests must be ignored under reset
        @(posedge CLK); #1;
        do_reset();
        idle_inputs();

        // Fill addresses 0..15 with known values, alternating ports
        for (int a = 0; a < 16; a++) begin
            if (a % 2 == 0) begin
                r0_req = 1; r0_we = 1; r0_a = AL'(a); r0_wd = $urandom;
            end else begin
                r1_req = 1; r1_we = 1; r1_a = AL'(a); r1_wd = $urandom;
            end
            tick();
            idle_inputs();
        end

        // Port 0 write A=5 then read A=5
        r0_req = 1; r0_we = 1; r0_a = 9'd5; r0_wd = 32'h1234;
        tick();
        chk("t1_wr_gnt", 32'(obs_g), 32'd0);
        chk("t1_wr_dmwe", 32'(obs_we), 32'd1);
        r0_we = 0;
        tick();
        chk("t1_rd_gnt", 32'(obs_g), 32'd0);
        chk("t1_rd_dmwe", 32'(obs_we), 32'd0);
        chk("t1_rd_val", R0_RD, 32'h1234);
        chk("t1_rd_rvalid", 32'(R0_RVALID), 32'd1);
        idle_inputs();
        tick();
        chk("t1_rvalid_pulse", 32'(R0_RVALID), 32'd0);

        // Port 1 writes A=7 while port 0 waits to read A=7 (last owner = 0)
        r1_req = 1; r1_we = 1; r1_a = 9'd7; r1_wd = 32'hDEAD;
        r0_req = 1; r0_we = 0; r0_a = 9'd7;
        tick();
        chk("raw_first_p1", 32'(obs_g), 32'd1);
        r1_req = 0; r1_we = 0;
        tick();
        chk("raw_then_p0", 32'(obs_g), 32'd0);
        chk("raw_rd", R0_RD, 32'hDEAD);
        idle_inputs();

        // Alternation from reset, no lock
        do_reset();
        r0_req = 1; r0_a = 9'd1; r1_req = 1; r1_a = 9'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_seq", 32'(obs_g), 32'(i % 2));
        end
        idle_inputs();

        // Lock held with port 0 also requesting
        do_reset();
        r0_req = 1; r0_a = 9'd3; r1_req = 1; r1_a = 9'd4; r1_lock = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            seq[i] = obs_g;
        end
        chk("lock_first_tie_p0", 32'(seq[0]), 32'd0);
        for (int i = 1; i <= 8; i++) chk("lock_p1_beat", 32'(seq[i]), 32'd1);
        chk("lock_release_p0", 32'(seq[9]), 32'd0);
        chk("lock_resume_p1", 32'(seq[10]), 32'd1);
        idle_inputs();

        // Reset dropped during a port 1 read
        tick();
        r1_req = 1; r1_we = 0; r1_a = 9'd3;
        #1;
        chk("mid_pre_gnt1", 32'(R1_GNT), 32'd1);
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("mid_gnt0", 32'(R0_GNT), 32'd0);
        chk("mid_gnt1", 32'(R1_GNT), 32'd0);
        chk("mid_dmwe", 32'(DMWE), 32'd0);
        @(posedge CLK); #1;
        chk("mid_rvalid1", 32'(R1_RVALID), 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        r0_req = 1; r0_a = 9'd6;
        tick();
        chk("post_rst_tie_p0", 32'(obs_g), 32'd0);
        idle_inputs();

`ifdef DM_ARB_STATS_EN
        do_reset();
        r0_req = 1; r0_a = 9'd1; r1_req = 1; r1_a = 9'd2;
        for (int i = 0; i < 10; i++) tick();
        chk("stats_stall0", 32'(STALL0_CNT), 32'd5);
        chk("stats_stall1", 32'(STALL1_CNT), 32'd5);
        idle_inputs();
`endif

        // Randomized traffic; requesters hold their request until granted
        for (int c = 0; c < 400; c++) begin
            if (!r0_req || obs_g == 0) begin
                r0_req = ($urandom_range(0, 3) != 0);
                r0_we  = 1'($urandom_range(0, 1));
                r0_a   = AL'($urandom_range(0, 15));
                r0_wd  = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                r0_req = 0;
            end
            if (!r1_req || obs_g == 1) begin
                r1_req  = ($urandom_range(0, 3) != 0);
                r1_we   = 1'($urandom_range(0, 1));
                r1_a    = AL'($urandom_range(0, 15));
                r1_wd   = $urandom;
                r1_lock = ($urandom_range(0, 2) != 0);
            end else if ($urandom_range(0, 7) == 0) begin
                r1_req = 0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
